// File: rtl/imm_gen_pkg.sv
// Shared definitions for the ID-stage immediate generator: RV32I/RV64I
// opcodes, immediate format codes and the output-buffer state encoding.
package imm_gen_pkg;

    // Major opcodes (instr[6:0]) that the decoder recognises
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // Immediate format classification carried on fmt_o
    localparam int unsigned FMT_W = 3;
    localparam logic [FMT_W-1:0] FMT_NONE = 3'd0;
    localparam logic [FMT_W-1:0] FMT_I    = 3'd1;
    localparam logic [FMT_W-1:0] FMT_SH   = 3'd2;
    localparam logic [FMT_W-1:0] FMT_S    = 3'd3;
    localparam logic [FMT_W-1:0] FMT_B    = 3'd4;
    localparam logic [FMT_W-1:0] FMT_U    = 3'd5;
    localparam logic [FMT_W-1:0] FMT_J    = 3'd6;

    // Occupancy of the output register plus skid slot
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    // funct3 values 001 (SLLI) and 101 (SRLI/SRAI) select the shift-amount form
    function automatic logic is_shift(input logic [2:0] funct3);
        return (funct3 == 3'b001) || (funct3 == 3'b101);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder.
// Ports:
//   instr_i    raw 32-bit instruction
//   imm_o      decoded immediate, sign-extended from instr[31] (shamt zero-extended)
//   fmt_o      format class (FMT_NONE..FMT_J)
//   illegal_o  opcode or encoding not supported at this XLEN
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]      instr_i,
    output logic [XLEN-1:0]  imm_o,
    output logic [FMT_W-1:0] fmt_o,
    output logic             illegal_o
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            sgn;
    logic [63:0]     imm_i64;
    logic [63:0]     imm_s64;
    logic [63:0]     imm_b64;
    logic [63:0]     imm_u64;
    logic [63:0]     imm_j64;
    logic [XLEN-1:0] shamt5;
    logic [XLEN-1:0] shamt6;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign sgn    = instr_i[31];

    // Every format is built at 64 bits and truncated, so one set of
    // expressions serves both XLEN values.
    assign imm_i64 = {{52{sgn}}, instr_i[31:20]};
    assign imm_s64 = {{52{sgn}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b64 = {{51{sgn}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u64 = {{32{sgn}}, instr_i[31:12], 12'b0};
    assign imm_j64 = {{43{sgn}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    assign shamt5 = XLEN'(instr_i[24:20]);
    assign shamt6 = XLEN'(instr_i[25:20]);

    // Opcode decode
    always_comb begin
        imm_o     = '0;
        fmt_o     = FMT_NONE;
        illegal_o = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_JALR: begin
                fmt_o = FMT_I;
                imm_o = XLEN'(imm_i64);
            end
            OPC_OP_IMM: begin
                if (is_shift(funct3)) begin
                    fmt_o = FMT_SH;
                    if (XLEN == 64) begin
                        imm_o = shamt6;
                    end else begin
                        imm_o     = shamt5;
                        // shamt[5] set is an out-of-range shift on RV32
                        illegal_o = instr_i[25];
                    end
                end else begin
                    fmt_o = FMT_I;
                    imm_o = XLEN'(imm_i64);
                end
            end
            OPC_OP_IMM_32: begin
                if (XLEN == 64) begin
                    if (is_shift(funct3)) begin
                        // word shifts only ever take a 5-bit amount
                        fmt_o = FMT_SH;
                        imm_o = shamt5;
                    end else begin
                        fmt_o = FMT_I;
                        imm_o = XLEN'(imm_i64);
                    end
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OPC_STORE: begin
                fmt_o = FMT_S;
                imm_o = XLEN'(imm_s64);
            end
            OPC_BRANCH: begin
                fmt_o = FMT_B;
                imm_o = XLEN'(imm_b64);
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt_o = FMT_U;
                imm_o = XLEN'(imm_u64);
            end
            OPC_JAL: begin
                fmt_o = FMT_J;
                imm_o = XLEN'(imm_j64);
            end
            OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: begin
                fmt_o = FMT_NONE;
            end
            OPC_OP_32: begin
                illegal_o = (XLEN != 64);
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered ID-stage immediate generator with pc+imm target adder and
// valid/ready handshakes. SKID=1 adds a second slot so ready_o can be a
// register; SKID=0 uses a single register and a combinational ready_o.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-low reset
//   flush_i             synchronous flush, empties the block
//   valid_i / ready_o   input handshake for instr_i / pc_i
//   valid_o / ready_i   output handshake for imm_o, fmt_o, illegal_o, pc_o, target_o
//   target_o            pc + imm modulo 2^XLEN
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SKID = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [31:0]      instr_i,
    input  logic [XLEN-1:0]  pc_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  imm_o,
    output logic [FMT_W-1:0] fmt_o,
    output logic             illegal_o,
    output logic [XLEN-1:0]  pc_o,
    output logic [XLEN-1:0]  target_o
);

    // Entry layout: {imm, fmt, illegal, pc, target}
    localparam int unsigned ENTRY_W = 3 * XLEN + FMT_W + 1;

    logic [XLEN-1:0]    dec_imm;
    logic [FMT_W-1:0]   dec_fmt;
    logic               dec_illegal;
    logic [XLEN-1:0]    dec_target;
    logic [ENTRY_W-1:0] in_entry;

    state_e             state_q, state_d;
    logic               valid_q, valid_d;
    logic [ENTRY_W-1:0] out_q, out_d;
    logic [ENTRY_W-1:0] skid_q, skid_d;

    logic               in_xfer;
    logic               out_xfer;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr_i   (instr_i),
        .imm_o     (dec_imm),
        .fmt_o     (dec_fmt),
        .illegal_o (dec_illegal)
    );

    // Target is computed before the register so the stage adds no output-side logic
    assign dec_target = pc_i + dec_imm;
    assign in_entry   = {dec_imm, dec_fmt, dec_illegal, pc_i, dec_target};

    assign in_xfer  = valid_i & ready_o;
    assign out_xfer = valid_q & ready_i;

    // Occupancy next-state and data steering
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d = ONE;
                    out_d   = in_entry;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    out_d = in_entry;
                end else if (in_xfer) begin
                    state_d = TWO;
                    skid_d  = in_entry;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_xfer) begin
                    state_d = ONE;
                    out_d   = skid_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        // Flush overrides every other event; stale data may stay in the registers
        if (flush_i) begin
            state_d = EMPTY;
        end
    end

    assign valid_d = (state_d != EMPTY);

    // State and data registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    // Input ready: registered with the skid slot, otherwise pass-through
    if (SKID != 0) begin : g_skid
        logic ready_q;
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                ready_q <= 1'b1;
            end else begin
                ready_q <= (state_d != TWO);
            end
        end
        assign ready_o = ready_q;
    end else begin : g_noskid
        // With no skid slot the block can only take data the cycle the output drains
        assign ready_o = ~valid_q | ready_i;
    end

    assign valid_o = valid_q;
    assign {imm_o, fmt_o, illegal_o, pc_o, target_o} = out_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one XLEN=32/SKID=1 instance and one
// XLEN=64/SKID=0 instance share the stimulus.
module tb_imm_gen_pipe;

    localparam int unsigned N = 17;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        valid;
    logic [31:0] instr;
    logic [63:0] pc;
    logic        rdy_in;

    logic        a_ready, a_valid, a_ill;
    logic [31:0] a_imm, a_pc, a_tgt;
    logic [2:0]  a_fmt;
    logic        b_ready, b_valid, b_ill;
    logic [63:0] b_imm, b_pc, b_tgt;
    logic [2:0]  b_fmt;

    int total = 0;
    int bad   = 0;

    imm_gen_pipe #(.XLEN(32), .SKID(1)) dut32 (
        .clk_i(clk), .rst_i(rst_n), .flush_i(flush), .valid_i(valid), .ready_o(a_ready),
        .instr_i(instr), .pc_i(pc[31:0]), .valid_o(a_valid), .ready_i(rdy_in),
        .imm_o(a_imm), .fmt_o(a_fmt), .illegal_o(a_ill), .pc_o(a_pc), .target_o(a_tgt)
    );

    imm_gen_pipe #(.XLEN(64), .SKID(0)) dut64 (
        .clk_i(clk), .rst_i(rst_n), .flush_i(flush), .valid_i(valid), .ready_o(b_ready),
        .instr_i(instr), .pc_i(pc), .valid_o(b_valid), .ready_i(rdy_in),
        .imm_o(b_imm), .fmt_o(b_fmt), .illegal_o(b_ill), .pc_o(b_pc), .target_o(b_tgt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decode vectors: instr, pc, then expected {imm, fmt, illegal, target} at XLEN=32 and 64
    logic [31:0] v_instr [N] = '{32'hFFF00093, 32'hFE000EE3, 32'hFE112C23, 32'h12345037,
                                 32'h80000017, 32'h8000006F, 32'h01000093, 32'h43F0D093,
                                 32'h00509093, 32'hFFF0809B, 32'h002081B3, 32'h002081BB,
                                 32'h0000007F, 32'h00000073, 32'h80012083, 32'h7FF08067,
                                 32'h0FF0000F};
    logic [63:0] v_pc [N] = '{64'h100, 64'h200, 64'h300, 64'h400, 64'h500, 64'h600,
                              64'hFFFFFFF0, 64'h700, 64'h800, 64'h900, 64'hA00, 64'hB00,
                              64'hC00, 64'hD00, 64'hE00, 64'hF00, 64'h1000};
    logic [63:0] e32_imm [N] = '{64'hFFFFFFFF, 64'hFFFFFFFC, 64'hFFFFFFF8, 64'h12345000,
                                 64'h80000000, 64'hFFF00000, 64'h10, 64'h1F, 64'h5, 64'h0,
                                 64'h0, 64'h0, 64'h0, 64'h0, 64'hFFFFF800, 64'h7FF, 64'h0};
    logic [2:0]  e32_fmt [N] = '{3'd1, 3'd4, 3'd3, 3'd5, 3'd5, 3'd6, 3'd1, 3'd2, 3'd2, 3'd0,
                                 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd0};
    logic        e32_ill [N] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                                 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [63:0] e32_tgt [N] = '{64'hFF, 64'h1FC, 64'h2F8, 64'h12345400, 64'h80000500,
                                 64'hFFF00600, 64'h0, 64'h71F, 64'h805, 64'h900, 64'hA00,
                                 64'hB00, 64'hC00, 64'hD00, 64'h600, 64'h16FF, 64'h1000};
    logic [63:0] e64_imm [N] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
                                 64'h12345000, 64'hFFFFFFFF80000000, 64'hFFFFFFFFFFF00000,
                                 64'h10, 64'h3F, 64'h5, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0,
                                 64'h0, 64'h0, 64'hFFFFFFFFFFFFF800, 64'h7FF, 64'h0};
    logic [2:0]  e64_fmt [N] = '{3'd1, 3'd4, 3'd3, 3'd5, 3'd5, 3'd6, 3'd1, 3'd2, 3'd2, 3'd1,
                                 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd0};
    logic        e64_ill [N] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [63:0] e64_tgt [N] = '{64'hFF, 64'h1FC, 64'h2F8, 64'h12345400, 64'hFFFFFFFF80000500,
                                 64'hFFFFFFFFFFF00600, 64'h100000000, 64'h73F, 64'h805, 64'h8FF,
                                 64'hA00, 64'hB00, 64'hC00, 64'hD00, 64'h600, 64'h16FF, 64'h1000};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] p);
        valid = v;
        instr = ins;
        pc    = p;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " a_valid"}, 64'(a_valid), 64'h0);
        chk({tag, " a_ready"}, 64'(a_ready), 64'h1);
        chk({tag, " a_imm"},   64'(a_imm),   64'h0);
        chk({tag, " a_fmt"},   64'(a_fmt),   64'h0);
        chk({tag, " a_ill"},   64'(a_ill),   64'h0);
        chk({tag, " a_pc"},    64'(a_pc),    64'h0);
        chk({tag, " a_tgt"},   64'(a_tgt),   64'h0);
        chk({tag, " b_valid"}, 64'(b_valid), 64'h0);
        chk({tag, " b_ready"}, 64'(b_ready), 64'h1);
        chk({tag, " b_imm"},   b_imm,        64'h0);
        chk({tag, " b_fmt"},   64'(b_fmt),   64'h0);
        chk({tag, " b_ill"},   64'(b_ill),   64'h0);
        chk({tag, " b_pc"},    b_pc,         64'h0);
        chk({tag, " b_tgt"},   b_tgt,        64'h0);
    endtask

    initial begin
        rst_n  = 1'b0;
        flush  = 1'b0;
        valid  = 1'b0;
        instr  = 32'h0;
        pc     = 64'h0;
        rdy_in = 1'b1;

        // Reset values
        #12;
        chk_reset_vals("rst");
        rst_n = 1'b1;
        tick();
        chk("post_rst a_valid", 64'(a_valid), 64'h0);

        // Streaming decode with ready_i high: one result per cycle, latency 1
        for (int i = 0; i < int'(N); i++) begin
            drive(1'b1, v_instr[i], v_pc[i]);
            tick();
            chk($sformatf("v%0d a_valid", i), 64'(a_valid), 64'h1);
            chk($sformatf("v%0d a_ready", i), 64'(a_ready), 64'h1);
            chk($sformatf("v%0d a_imm", i),   64'(a_imm),   e32_imm[i]);
            chk($sformatf("v%0d a_fmt", i),   64'(a_fmt),   64'(e32_fmt[i]));
            chk($sformatf("v%0d a_ill", i),   64'(a_ill),   64'(e32_ill[i]));
            chk($sformatf("v%0d a_pc", i),    64'(a_pc),    64'(v_pc[i][31:0]));
            chk($sformatf("v%0d a_tgt", i),   64'(a_tgt),   e32_tgt[i]);
            chk($sformatf("v%0d b_valid", i), 64'(b_valid), 64'h1);
            chk($sformatf("v%0d b_imm", i),   b_imm,        e64_imm[i]);
            chk($sformatf("v%0d b_fmt", i),   64'(b_fmt),   64'(e64_fmt[i]));
            chk($sformatf("v%0d b_ill", i),   64'(b_ill),   64'(e64_ill[i]));
            chk($sformatf("v%0d b_pc", i),    b_pc,         v_pc[i]);
            chk($sformatf("v%0d b_tgt", i),   b_tgt,        e64_tgt[i]);
        end
        drive(1'b0, 32'h0, 64'h0);
        tick();
        chk("drain a_valid", 64'(a_valid), 64'h0);
        chk("drain b_valid", 64'(b_valid), 64'h0);

        // Back-pressure: skid fills, holds, drains in order
        rdy_in = 1'b0;
        drive(1'b1, 32'h00100093, 64'h1000);
        #1;
        chk("sk0 a_ready", 64'(a_ready), 64'h1);
        chk("sk0 b_ready", 64'(b_ready), 64'h1);
        tick();
        chk("sk1 a_valid", 64'(a_valid), 64'h1);
        chk("sk1 a_imm",   64'(a_imm),   64'h1);
        chk("sk1 a_ready", 64'(a_ready), 64'h1);
        chk("sk1 b_imm",   b_imm,        64'h1);
        chk("sk1 b_ready", 64'(b_ready), 64'h0);
        drive(1'b1, 32'h00200093, 64'h1004);
        tick();
        chk("sk2 a_ready", 64'(a_ready), 64'h0);
        chk("sk2 a_imm",   64'(a_imm),   64'h1);
        chk("sk2 a_pc",    64'(a_pc),    64'h1000);
        chk("sk2 b_imm",   b_imm,        64'h1);
        drive(1'b1, 32'h00300093, 64'h1008);
        tick();
        chk("sk3 a_ready", 64'(a_ready), 64'h0);
        chk("sk3 a_imm",   64'(a_imm),   64'h1);
        chk("sk3 a_valid", 64'(a_valid), 64'h1);
        rdy_in = 1'b1;
        #1;
        chk("sk3 b_ready", 64'(b_ready), 64'h1);
        chk("sk3b a_ready", 64'(a_ready), 64'h0);
        tick();
        chk("sk4 a_imm",   64'(a_imm),   64'h2);
        chk("sk4 a_pc",    64'(a_pc),    64'h1004);
        chk("sk4 a_ready", 64'(a_ready), 64'h1);
        chk("sk4 b_imm",   b_imm,        64'h3);
        tick();
        chk("sk5 a_imm",   64'(a_imm),   64'h3);
        chk("sk5 a_pc",    64'(a_pc),    64'h1008);
        chk("sk5 a_valid", 64'(a_valid), 64'h1);
        drive(1'b0, 32'h0, 64'h0);
        tick();
        chk("sk6 a_valid", 64'(a_valid), 64'h0);
        chk("sk6 b_valid", 64'(b_valid), 64'h0);

        // Flush while full, with an input offered
        rdy_in = 1'b0;
        drive(1'b1, 32'h00400093, 64'h2000);
        tick();
        drive(1'b1, 32'h00500093, 64'h2004);
        tick();
        chk("fl0 a_ready", 64'(a_ready), 64'h0);
        flush = 1'b1;
        drive(1'b1, 32'h00600093, 64'h2008);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 64'h0);
        chk("fl1 a_valid", 64'(a_valid), 64'h0);
        chk("fl1 a_ready", 64'(a_ready), 64'h1);
        chk("fl1 b_valid", 64'(b_valid), 64'h0);
        chk("fl1 b_ready", 64'(b_ready), 64'h1);
        rdy_in = 1'b1;
        tick();
        tick();
        chk("fl2 a_valid", 64'(a_valid), 64'h0);
        drive(1'b1, 32'h00700093, 64'h3000);
        tick();
        chk("fl3 a_valid", 64'(a_valid), 64'h1);
        chk("fl3 a_imm",   64'(a_imm),   64'h7);
        chk("fl3 a_pc",    64'(a_pc),    64'h3000);
        chk("fl3 b_imm",   b_imm,        64'h7);
        // Flush wins over a simultaneous accepted input
        flush = 1'b1;
        drive(1'b1, 32'h00800093, 64'h3004);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 64'h0);
        chk("fl4 a_valid", 64'(a_valid), 64'h0);
        chk("fl4 b_valid", 64'(b_valid), 64'h0);
        tick();
        chk("fl5 a_valid", 64'(a_valid), 64'h0);
        chk("fl5 b_valid", 64'(b_valid), 64'h0);

        // Asynchronous reset mid-cycle while full
        rdy_in = 1'b0;
        drive(1'b1, 32'h00900093, 64'h4000);
        tick();
        drive(1'b1, 32'h00A00093, 64'h4004);
        tick();
        chk("rs0 a_ready", 64'(a_ready), 64'h0);
        chk("rs0 a_valid", 64'(a_valid), 64'h1);
        drive(1'b0, 32'h0, 64'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rs1");
        #1;
        rst_n = 1'b1;
        tick();
        chk("rs2 a_valid", 64'(a_valid), 64'h0);
        chk("rs2 b_valid", 64'(b_valid), 64'h0);
        rdy_in = 1'b1;
        drive(1'b1, 32'h00B00093, 64'h5000);
        tick();
        chk("rs3 a_valid", 64'(a_valid), 64'h1);
        chk("rs3 a_imm",   64'(a_imm),   64'hB);
        chk("rs3 a_pc",    64'(a_pc),    64'h5000);
        chk("rs3 a_tgt",   64'(a_tgt),   64'h500B);
        chk("rs3 b_valid", 64'(b_valid), 64'h1);
        chk("rs3 b_tgt",   b_tgt,        64'h500B);
        drive(1'b0, 32'h0, 64'h0);
        tick();
        chk("rs4 a_valid", 64'(a_valid), 64'h0);
        chk("rs4 b_valid", 64'(b_valid), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
